// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: sequences new-game, serve, play and game-over
// phases, keeps saturating BCD scores and declares the winner.
module pong_game_ctrl #(
  parameter int WIN_SCORE   = 5,
  parameter int SERVE_TICKS = 120,
  parameter int OVER_TICKS  = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       refresh_tick,
  input  logic [1:0] hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner,
  output logic [1:0] game_state
);

  typedef enum logic [1:0] {
    S_NEWGAME = 2'b00,
    S_PLAY    = 2'b01,
    S_NEWBALL = 2'b10,
    S_OVER    = 2'b11
  } state_t;

  localparam logic [3:0] LP_WIN   = 4'(WIN_SCORE);
  localparam logic [7:0] LP_SERVE = 8'(SERVE_TICKS);
  localparam logic [7:0] LP_OVER  = 8'(OVER_TICKS);

  state_t     r_state, w_stateNext;
  logic [3:0] r_p1Score, r_p2Score, w_p1Next, w_p2Next, w_p1Inc, w_p2Inc;
  logic [1:0] r_winner, w_winnerNext;
  logic [7:0] r_timer, w_timerNext;
  logic [3:0] r_btnPrev;
  logic       w_start;

  assign w_start = (|btn) & ~(|r_btnPrev);
  assign w_p1Inc = (r_p1Score >= 4'd9) ? 4'd9 : r_p1Score + 4'd1;
  assign w_p2Inc = (r_p2Score >= 4'd9) ? 4'd9 : r_p2Score + 4'd1;

  // btn_prev resets to all-ones so a button held through reset cannot start a game.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_NEWGAME;
      r_p1Score <= 4'd0;
      r_p2Score <= 4'd0;
      r_winner  <= 2'b00;
      r_timer   <= 8'd0;
      r_btnPrev <= 4'hF;
    end else begin
      r_state   <= w_stateNext;
      r_p1Score <= w_p1Next;
      r_p2Score <= w_p2Next;
      r_winner  <= w_winnerNext;
      r_timer   <= w_timerNext;
      r_btnPrev <= btn;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_p1Next     = r_p1Score;
    w_p2Next     = r_p2Score;
    w_winnerNext = r_winner;
    w_timerNext  = r_timer;
    case (r_state)
      S_NEWGAME: begin
        if (w_start) w_stateNext = S_PLAY;
      end
      S_PLAY: begin
        // hit[1] has priority; a miss with no exit side is ignored.
        if (miss && hit[1]) begin
          w_p1Next = w_p1Inc;
          if (w_p1Inc == LP_WIN) begin
            w_stateNext  = S_OVER;
            w_winnerNext = 2'b01;
            w_timerNext  = LP_OVER;
          end else begin
            w_stateNext = S_NEWBALL;
            w_timerNext = LP_SERVE;
          end
        end else if (miss && hit[0]) begin
          w_p2Next = w_p2Inc;
          if (w_p2Inc == LP_WIN) begin
            w_stateNext  = S_OVER;
            w_winnerNext = 2'b10;
            w_timerNext  = LP_OVER;
          end else begin
            w_stateNext = S_NEWBALL;
            w_timerNext = LP_SERVE;
          end
        end
      end
      S_NEWBALL: begin
        if (r_timer == 8'd0)   w_stateNext = S_PLAY;
        else if (refresh_tick) w_timerNext = r_timer - 8'd1;
      end
      S_OVER: begin
        if (r_timer == 8'd0) begin
          if (w_start) begin
            w_stateNext  = S_NEWGAME;
            w_p1Next     = 4'd0;
            w_p2Next     = 4'd0;
            w_winnerNext = 2'b00;
          end
        end else if (refresh_tick) begin
          w_timerNext = r_timer - 8'd1;
        end
      end
      default: w_stateNext = S_NEWGAME;
    endcase
  end

  assign game_state = r_state;
  assign gra_still  = (r_state != S_PLAY);
  assign p1_score   = r_p1Score;
  assign p2_score   = r_p2Score;
  assign winner     = r_winner;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: expectations are queued as stimulus
// is driven and popped against the packed output vector after each step.
module tb_pong_game_ctrl;

  localparam logic [1:0] ST_NEWGAME = 2'b00;
  localparam logic [1:0] ST_PLAY    = 2'b01;
  localparam logic [1:0] ST_NEWBALL = 2'b10;
  localparam logic [1:0] ST_OVER    = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn = 4'd0;
  logic       refreshTick = 1'b0;
  logic [1:0] hit = 2'd0;
  logic       miss = 1'b0;
  logic       graStill;
  logic [3:0] p1Score, p2Score;
  logic [1:0] winner, gameState;
  logic [12:0] obs;

  typedef struct {
    string       name;
    logic [12:0] vec;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   nChecks = 0;
  int   nErrors = 0;

  pong_game_ctrl #(.WIN_SCORE(5), .SERVE_TICKS(120), .OVER_TICKS(180)) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .refresh_tick(refreshTick),
    .hit(hit),
    .miss(miss),
    .gra_still(graStill),
    .p1_score(p1Score),
    .p2_score(p2Score),
    .winner(winner),
    .game_state(gameState)
  );

  assign obs = {graStill, gameState, p1Score, p2Score, winner};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [12:0] mkVec(input logic [1:0] st, input logic [3:0] s1,
                                        input logic [3:0] s2, input logic [1:0] w);
    return {(st != ST_PLAY), st, s1, s2, w};
  endfunction

  task automatic pushExp(input string n, input logic [12:0] v);
    exp_t e;
    e.name = n;
    e.vec  = v;
    expQ.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      refreshTick = 1'b1;
      step(1);
      refreshTick = 1'b0;
      step(1);
    end
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    step(1);
    btn = 4'd0;
    step(1);
  endtask

  task automatic test_reset;
    btn = 4'b0001;
    reset = 1'b1;
    pushExp("reset_state", mkVec(ST_NEWGAME, 4'd0, 4'd0, 2'b00));
    step(2);
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
    reset = 1'b0;
    pushExp("held_btn_no_start", mkVec(ST_NEWGAME, 4'd0, 4'd0, 2'b00));
    step(3);
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
    btn = 4'd0;
    step(1);
    btn = 4'b0100;
    pushExp("start_to_play", mkVec(ST_PLAY, 4'd0, 4'd0, 2'b00));
    step(1);
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
    btn = 4'd0;
    step(1);
  endtask

  task automatic test_score_p1;
    miss = 1'b1;
    hit  = 2'b10;
    pushExp("p1_first_point", mkVec(ST_NEWBALL, 4'd1, 4'd0, 2'b00));
    step(1);
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
    pushExp("p1_scored_once", mkVec(ST_NEWBALL, 4'd1, 4'd0, 2'b00));
    step(4);
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
    miss = 1'b0;
    hit  = 2'b00;
    pushExp("serve_119_ticks", mkVec(ST_NEWBALL, 4'd1, 4'd0, 2'b00));
    ticks(119);
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
    pushExp("serve_120_ticks", mkVec(ST_PLAY, 4'd1, 4'd0, 2'b00));
    ticks(1);
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
  endtask

  task automatic test_both_hits;
    miss = 1'b1;
    hit  = 2'b11;
    pushExp("hit11_p1_priority", mkVec(ST_NEWBALL, 4'd2, 4'd0, 2'b00));
    step(1);
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
    miss = 1'b0;
    hit  = 2'b00;
    ticks(120);
    miss = 1'b1;
    pushExp("miss_no_hit_ignored", mkVec(ST_PLAY, 4'd2, 4'd0, 2'b00));
    step(3);
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
    miss = 1'b0;
  endtask

  // A tick on the scoring edge must not shorten the serve pause.
  task automatic test_tick_on_score;
    miss = 1'b1;
    hit  = 2'b01;
    refreshTick = 1'b1;
    pushExp("p2_point_with_tick", mkVec(ST_NEWBALL, 4'd2, 4'd1, 2'b00));
    step(1);
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
    miss = 1'b0;
    hit  = 2'b00;
    refreshTick = 1'b0;
    pushExp("load_wins_119", mkVec(ST_NEWBALL, 4'd2, 4'd1, 2'b00));
    ticks(119);
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
    pushExp("load_wins_120", mkVec(ST_PLAY, 4'd2, 4'd1, 2'b00));
    ticks(1);
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
  endtask

  task automatic test_reset_mid_newball;
    miss = 1'b1; hit = 2'b10; step(1);
    miss = 1'b0; hit = 2'b00; ticks(120);
    miss = 1'b1; hit = 2'b01; step(1);
    miss = 1'b0; hit = 2'b00;
    pushExp("pre_reset_3_2", mkVec(ST_NEWBALL, 4'd3, 4'd2, 2'b00));
    ticks(63);
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
    #3;
    reset = 1'b1;
    pushExp("async_reset", mkVec(ST_NEWGAME, 4'd0, 4'd0, 2'b00));
    #1;
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_game_over;
    btn = 4'b1000;
    pushExp("restart_play", mkVec(ST_PLAY, 4'd0, 4'd0, 2'b00));
    step(1);
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
    btn = 4'd0;
    for (int k = 1; k <= 5; k++) begin
      miss = 1'b1; hit = 2'b01; step(1);
      miss = 1'b0; hit = 2'b00;
      if (k < 5) ticks(120);
    end
    pushExp("p2_wins", mkVec(ST_OVER, 4'd0, 4'd5, 2'b10));
    step(1);
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
    ticks(10);
    pushExp("start_at_tick10_ignored", mkVec(ST_OVER, 4'd0, 4'd5, 2'b10));
    press(4'b0010);
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
    ticks(169);
    pushExp("start_at_tick179_ignored", mkVec(ST_OVER, 4'd0, 4'd5, 2'b10));
    press(4'b0001);
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
    ticks(1);
    pushExp("restart_after_over", mkVec(ST_NEWGAME, 4'd0, 4'd0, 2'b00));
    press(4'b0100);
    cur = expQ.pop_front(); nChecks++;
    if (obs !== cur.vec) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", cur.name, obs, cur.vec); end
  endtask

  initial begin
    test_reset();
    test_score_p1();
    test_both_hits();
    test_tick_on_score();
    test_reset_mid_newball();
    test_game_over();
    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
